// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and registered output stage for a shared data channel.
// Define MUX_ARB_FIXED_PRIO_EN to pin the search start at 0 (fixed priority).
module mux_rr_arbiter #(
    parameter int NUM_INPUTS = 8,
    parameter int NUM_BITS = 32,
    localparam int SEL_W = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BITS-1:0]   a [NUM_INPUTS],
    input  logic [NUM_INPUTS-1:0] in_valid,
    output logic [NUM_INPUTS-1:0] in_ready,
    output logic [NUM_BITS-1:0]   out,
    output logic [SEL_W-1:0]      sel,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic [SEL_W-1:0] cand;
    logic             any_req;
    logic             can_load;
    logic             load;
    int               idx;

    assign out_valid = (state_q == FULL);
    assign can_load  = !out_valid || out_ready;
    assign any_req   = |in_valid;
    assign load      = can_load && any_req && !rst;

    // Circular search from ptr; scanning backwards leaves the nearest hit.
    always_comb begin
        winner = '0;
        cand   = '0;
        idx    = 0;
        for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_INPUTS) begin
                idx = idx - NUM_INPUTS;
            end
            cand = SEL_W'(idx);
            if (in_valid[cand]) begin
                winner = cand;
            end
        end
    end

    // Grant only the winner, and only when the output slot can take a word.
    always_comb begin
        in_ready = '0;
        if (load) begin
            in_ready[winner] = 1'b1;
        end
    end

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [SEL_W-1:0] ptr_next;

    assign ptr_next = (winner == SEL_W'(NUM_INPUTS - 1)) ?
                      '0 : winner + 1'b1;

    // Advance the search start just past the last granted requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= ptr_next;
        end
    end
`endif

    // Output slot occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Load wins over drain, so accept-and-reload keeps the slot full.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = FULL;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    // Capture the granted word and its source; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            sel <= '0;
        end else if (load) begin
            out <= a[winner];
            sel <= winner;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed plan plus random traffic.
// Honours MUX_ARB_FIXED_PRIO_EN to select the matching reference policy.
module tb_mux_rr_arbiter;

    localparam int N = 8;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        int           s;
    } item_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a [N];
    logic [N-1:0] in_valid;
    logic [N-1:0] in_ready;
    logic [W-1:0] out;
    logic [2:0]   sel;
    logic         out_valid;
    logic         out_ready;

    item_t q[$];
    int    seen[$];
    int    exp_s[$];
    int    total = 0;
    int    bad = 0;
    int    mptr = 0;
    bit    pend = 1'b0;
    item_t pend_it;
    bit    rst_prev = 1'b0;

    always #5 clk = ~clk;

    mux_rr_arbiter #(
        .NUM_INPUTS(N),
        .NUM_BITS(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out(out),
        .sel(sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic void check_seq(string name);
        bit ok;
        ok = (seen.size() == exp_s.size());
        for (int i = 0; ok && i < exp_s.size(); i++) begin
            if (seen[i] != exp_s[i]) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%p required=%p", name, seen, exp_s);
        end
    endfunction

    // First valid index walking circularly from p; -1 if none.
    function automatic int pick(logic [N-1:0] v, int p);
        int j;
        logic [2:0] jj;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            jj = j[2:0];
            if (v[jj]) return j;
        end
        return -1;
    endfunction

    // Reference: grant prediction and in_ready check, mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] er;
        logic [2:0]   wi;
        int           w;
        bit           cl;
        er = '0;
        w = pick(in_valid, mptr);
        wi = w[2:0];
        cl = (q.size() == 0) || out_ready;
        if (!rst && cl && w >= 0) er[wi] = 1'b1;
        chk("in_ready", 64'(in_ready), 64'(er));
        pend <= (!rst && cl && w >= 0);
        if (w >= 0) pend_it <= '{a[wi], w};
    end

    // Reference: commit predicted transfer at the clock edge.
    always @(posedge clk) begin
        rst_prev <= rst;
        if (rst) begin
            q.delete();
            mptr <= 0;
        end else if (pend) begin
            q.push_back(pend_it);
`ifdef MUX_ARB_FIXED_PRIO_EN
            mptr <= 0;
`else
            mptr <= (pend_it.s + 1) % N;
`endif
        end
    end

    // Monitor: compare presented word with the scoreboard head.
    always @(negedge clk) begin
        if (rst_prev) begin
            chk("reset_state", 64'({out_valid, sel, out}), 64'd0);
        end
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
            chk("out", 64'(out), 64'(q[0].d));
            chk("sel", 64'(sel), 64'(q[0].s));
            if (out_ready) begin
                seen.push_back(int'(sel));
                void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic r, input logic [N-1:0] v,
                        input logic rdy);
        rst = r;
        in_valid = v;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        a[0] = 2;  a[1] = 4;  a[2] = 8;  a[3] = 16;
        a[4] = 32; a[5] = 33; a[6] = 34; a[7] = 35;

        repeat (2) step(1'b1, 8'hFF, 1'b1);

        seen.delete();
        repeat (9) step(1'b0, 8'hFF, 1'b1);
        drain(2);
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp_s = {0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
        exp_s = {0, 1, 2, 3, 4, 5, 6, 7, 0};
`endif
        check_seq("rotation");

        seen.delete();
        step(1'b0, 8'h08, 1'b1);
        repeat (5) step(1'b0, 8'h08, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        drain(1);
        exp_s = {3};
        check_seq("backpressure");

        seen.delete();
        step(1'b0, 8'h80, 1'b1);
        repeat (3) step(1'b0, 8'h81, 1'b1);
        drain(2);
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp_s = {7, 0, 0, 0};
`else
        exp_s = {7, 0, 7, 0};
`endif
        check_seq("wrap");

        seen.delete();
        step(1'b0, 8'h20, 1'b1);
        step(1'b0, 8'h40, 1'b1);
        drain(2);
        exp_s = {5, 6};
        check_seq("accept_load");

        seen.delete();
        step(1'b0, 8'h40, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        repeat (2) step(1'b0, 8'hFF, 1'b1);
        drain(2);
`ifdef MUX_ARB_FIXED_PRIO_EN
        exp_s = {0, 0};
`else
        exp_s = {0, 1};
`endif
        check_seq("reset_mid");

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) a[i] = $urandom;
            step($urandom_range(0, 99) == 0,
                 ($urandom_range(0, 7) == 0) ? 8'hFF :
                 8'($urandom & $urandom),
                 $urandom_range(0, 3) != 0);
        end
        drain(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
